// File: rtl/risc_v_mike_uart_ctrl_pkg.sv
// Shared types and constants for the memory-mapped UART_MIKE controller.
package risc_v_mike_uart_ctrl_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {TxIdle, TxSend, TxWait, TxClr} t_uart_tx_state;
  typedef enum logic {RxIdle, RxClr} t_uart_rx_state;

  localparam logic [1:0] UART_REG_TXDATA = 2'd0;
  localparam logic [1:0] UART_REG_RXDATA = 2'd1;
  localparam logic [1:0] UART_REG_STATUS = 2'd2;
  localparam logic [1:0] UART_REG_CTRL   = 2'd3;

  localparam int unsigned STAT_TX_FULL  = 0;
  localparam int unsigned STAT_TX_EMPTY = 1;
  localparam int unsigned STAT_RX_EMPTY = 2;
  localparam int unsigned STAT_RX_FULL  = 3;
  localparam int unsigned STAT_RX_OVR   = 4;
  localparam int unsigned STAT_TX_OVF   = 5;
  localparam int unsigned STAT_PAR_ERR  = 6;
  localparam int unsigned STAT_TX_BUSY  = 7;
  localparam int unsigned STAT_TX_IE    = 8;

endpackage

// File: rtl/risc_v_mike_sync_fifo.sv
// Synchronous FIFO with flush; push on a full FIFO is accepted only alongside a pop.
module risc_v_mike_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // Flush wins over both sides; a full FIFO accepts a push only if a pop frees a slot.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/risc_v_mike_uart_ctrl.sv
// Memory-mapped UART controller: TX/RX FIFOs plus hardware send/clear handshakes
// towards UART_MIKE, exposed as four word registers.
module risc_v_mike_uart_ctrl #(
  parameter int unsigned UART_DATA_WIDTH = risc_v_mike_uart_ctrl_pkg::UART_DATA_WIDTH,
  parameter int unsigned TX_FIFO_DEPTH   = 4,
  parameter int unsigned RX_FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [1:0]                 bus_addr,
  input  logic                       bus_wr,
  input  logic                       bus_rd,
  input  logic [31:0]                bus_wr_data,
  output logic [31:0]                bus_rd_data,
  output logic [UART_DATA_WIDTH-1:0] uart_tx_data,
  output logic                       uart_tx_send,
  input  logic                       uart_tx_flag,
  output logic                       uart_tx_flag_clr,
  input  logic                       uart_rx_flag,
  input  logic [UART_DATA_WIDTH-1:0] uart_rx_data,
  output logic                       uart_rx_flag_clr,
  input  logic                       uart_parity_error,
  output logic                       irq
);

  import risc_v_mike_uart_ctrl_pkg::*;

  logic                       tx_wr, rx_rd, ctrl_wr;
  logic                       sticky_clr, tx_flush, rx_flush;
  logic                       tx_full, tx_empty, rx_full, rx_empty;
  logic [UART_DATA_WIDTH-1:0] tx_head, rx_head;
  logic                       tx_pop, rx_pop, rx_push;
  logic                       tx_ovf_q, rx_ovr_q, par_err_q, tx_ie_q;
  logic [8:0]                 status;
  logic                       unused_wr_data;
  t_uart_tx_state             tx_state_q, tx_state_d;
  t_uart_rx_state             rx_state_q, rx_state_d;

  assign tx_wr          = bus_wr & (bus_addr == UART_REG_TXDATA);
  assign ctrl_wr        = bus_wr & (bus_addr == UART_REG_CTRL);
  assign rx_rd          = bus_rd & (bus_addr == UART_REG_RXDATA);
  assign sticky_clr     = ctrl_wr & bus_wr_data[0];
  assign tx_flush       = ctrl_wr & bus_wr_data[1];
  assign rx_flush       = ctrl_wr & bus_wr_data[2];
  assign rx_pop         = rx_rd & ~rx_empty & ~rx_flush;
  assign unused_wr_data = ^bus_wr_data[31:UART_DATA_WIDTH];

  risc_v_mike_sync_fifo #(.WIDTH(UART_DATA_WIDTH), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (tx_wr),
    .pop     (tx_pop),
    .flush   (tx_flush),
    .wr_data (bus_wr_data[UART_DATA_WIDTH-1:0]),
    .full    (tx_full),
    .empty   (tx_empty),
    .rd_data (tx_head)
  );

  risc_v_mike_sync_fifo #(.WIDTH(UART_DATA_WIDTH), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (rx_push),
    .pop     (rx_rd),
    .flush   (rx_flush),
    .wr_data (uart_rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .rd_data (rx_head)
  );

  // TX FSM
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) tx_state_q <= TxIdle;
    else        tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TxIdle:  if (!tx_empty && !tx_flush) tx_state_d = TxSend;
      TxSend:  tx_state_d = TxWait;
      TxWait:  if (uart_tx_flag) tx_state_d = TxClr;
      TxClr:   if (!uart_tx_flag) tx_state_d = TxIdle;
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    tx_pop           = 1'b0;
    uart_tx_send     = 1'b0;
    uart_tx_flag_clr = 1'b0;
    unique case (tx_state_q)
      TxIdle:  tx_pop = ~tx_empty & ~tx_flush;
      TxSend:  uart_tx_send = 1'b1;
      TxClr:   uart_tx_flag_clr = 1'b1;
      default: ;
    endcase
  end

  // RX FSM
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rx_state_q <= RxIdle;
    else        rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RxIdle:  if (uart_rx_flag) rx_state_d = RxClr;
      RxClr:   if (!uart_rx_flag) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    rx_push          = 1'b0;
    uart_rx_flag_clr = 1'b0;
    unique case (rx_state_q)
      RxIdle:  rx_push = uart_rx_flag;
      RxClr:   uart_rx_flag_clr = 1'b1;
      default: ;
    endcase
  end

  // Sticky flags: a same-cycle set overrides the clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_ovf_q     <= 1'b0;
      rx_ovr_q     <= 1'b0;
      par_err_q    <= 1'b0;
      tx_ie_q      <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      tx_ovf_q  <= (tx_ovf_q & ~sticky_clr) | (tx_wr & tx_full & ~tx_pop & ~tx_flush);
      rx_ovr_q  <= (rx_ovr_q & ~sticky_clr) | (rx_push & rx_full & ~rx_pop & ~rx_flush);
      par_err_q <= (par_err_q & ~sticky_clr) | (rx_push & uart_parity_error);
      if (ctrl_wr) tx_ie_q <= bus_wr_data[3];
      if (tx_pop)  uart_tx_data <= tx_head;
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_TX_EMPTY] = tx_empty;
    status[STAT_RX_EMPTY] = rx_empty;
    status[STAT_RX_FULL]  = rx_full;
    status[STAT_RX_OVR]   = rx_ovr_q;
    status[STAT_TX_OVF]   = tx_ovf_q;
    status[STAT_PAR_ERR]  = par_err_q;
    status[STAT_TX_BUSY]  = (tx_state_q != TxIdle);
    status[STAT_TX_IE]    = tx_ie_q;
  end

  always_comb begin
    bus_rd_data = '0;
    unique case (bus_addr)
      UART_REG_RXDATA: if (!rx_empty) bus_rd_data = 32'(rx_head);
      UART_REG_STATUS: bus_rd_data = 32'(status);
      UART_REG_CTRL:   bus_rd_data[3] = tx_ie_q;
      default:         ;
    endcase
  end

  assign irq = ~rx_empty | (tx_empty & tx_ie_q);

endmodule

// File: tb/tb_risc_v_mike_uart_ctrl.sv
// Directed bench for risc_v_mike_uart_ctrl with TX/RX byte scoreboards.
module tb_risc_v_mike_uart_ctrl;
  import risc_v_mike_uart_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [1:0]  bus_addr = '0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [31:0] bus_wr_data = '0;
  logic [31:0] bus_rd_data;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_send;
  logic        uart_tx_flag = 1'b0;
  logic        uart_tx_flag_clr;
  logic        uart_rx_flag = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_flag_clr;
  logic        uart_parity_error = 1'b0;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  int          sends = 0;
  logic [7:0]  tx_sb[$];
  logic [7:0]  rx_sb[$];
  logic [7:0]  mon_exp;
  logic [31:0] r;

  risc_v_mike_uart_ctrl #(
    .UART_DATA_WIDTH (8),
    .TX_FIFO_DEPTH   (4),
    .RX_FIFO_DEPTH   (4)
  ) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .bus_addr          (bus_addr),
    .bus_wr            (bus_wr),
    .bus_rd            (bus_rd),
    .bus_wr_data       (bus_wr_data),
    .bus_rd_data       (bus_rd_data),
    .uart_tx_data      (uart_tx_data),
    .uart_tx_send      (uart_tx_send),
    .uart_tx_flag      (uart_tx_flag),
    .uart_tx_flag_clr  (uart_tx_flag_clr),
    .uart_rx_flag      (uart_rx_flag),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_flag_clr  (uart_rx_flag_clr),
    .uart_parity_error (uart_parity_error),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every send must match the oldest byte the bench expects to leave; none expected -> X.
  always @(negedge clk) begin
    if (n_rst && uart_tx_send) begin
      sends++;
      if (tx_sb.size() != 0) mon_exp = tx_sb.pop_front();
      else mon_exp = 'x;
      check("tx_send_byte", 32'(uart_tx_data), 32'(mon_exp));
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_addr = a; bus_wr_data = d; bus_wr = 1'b1;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus_addr = a; bus_rd = 1'b1;
    #1 d = bus_rd_data;
    @(negedge clk);
    bus_rd = 1'b0;
  endtask

  task automatic wait_tx_clr(input string tag);
    int n = 0;
    while (uart_tx_flag_clr !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check(tag, 32'(uart_tx_flag_clr), 32'd1);
  endtask

  task automatic wait_rx_clr(input string tag);
    int n = 0;
    while (uart_rx_flag_clr !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check(tag, 32'(uart_rx_flag_clr), 32'd1);
  endtask

  task automatic finish_tx(input string tag);
    uart_tx_flag = 1'b1;
    wait_tx_clr({tag, "_clr"});
    @(negedge clk);
    check({tag, "_clr_held"}, 32'(uart_tx_flag_clr), 32'd1);
    uart_tx_flag = 1'b0;
    @(negedge clk);
    check({tag, "_clr_drop"}, 32'(uart_tx_flag_clr), 32'd0);
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic par);
    uart_rx_data = b; uart_parity_error = par; uart_rx_flag = 1'b1;
    wait_rx_clr("rx_clr");
    uart_rx_flag = 1'b0; uart_parity_error = 1'b0;
    @(negedge clk);
    check("rx_clr_drop", 32'(uart_rx_flag_clr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    rd(UART_REG_STATUS, r);
    check("reset_status", r, 32'h06);
    check("reset_outputs", {28'(uart_tx_data), uart_tx_send, uart_tx_flag_clr,
                            uart_rx_flag_clr, irq}, 32'd0);

    // TX single byte
    tx_sb.push_back(8'h41);
    wr(UART_REG_TXDATA, 32'h41);
    check("tx_send_early", 32'(uart_tx_send), 32'd0);
    @(negedge clk);
    check("tx_send_pulse", 32'(uart_tx_send), 32'd1);
    check("tx_data", 32'(uart_tx_data), 32'h41);
    @(negedge clk);
    check("tx_send_one_cycle", 32'(uart_tx_send), 32'd0);
    rd(UART_REG_STATUS, r);
    check("tx_busy_status", r, 32'h86);
    finish_tx("tx_single");
    rd(UART_REG_STATUS, r);
    check("tx_idle_status", r, 32'h06);

    // TX overflow: 0x10 in flight, 0x11..0x14 queued, 0x15 dropped
    for (int i = 0; i < 6; i++) begin
      if (i < 5) tx_sb.push_back(8'(8'h10 + i));
      wr(UART_REG_TXDATA, 32'(32'h10 + i));
    end
    rd(UART_REG_STATUS, r);
    check("tx_ovf_status", r, 32'hA5);
    wr(UART_REG_CTRL, 32'h1);
    rd(UART_REG_STATUS, r);
    check("tx_ovf_cleared", r, 32'h85);
    for (int i = 0; i < 5; i++) finish_tx("tx_drain");
    rd(UART_REG_STATUS, r);
    check("tx_drained_status", r, 32'h06);
    check("tx_sb_empty", 32'(tx_sb.size()), 32'd0);

    // Interrupt enable
    wr(UART_REG_CTRL, 32'h8);
    check("irq_tx_ie", 32'(irq), 32'd1);
    rd(UART_REG_CTRL, r);
    check("ctrl_read", r, 32'h8);
    rd(UART_REG_STATUS, r);
    check("status_tx_ie", r, 32'h106);
    wr(UART_REG_CTRL, 32'h0);
    check("irq_off", 32'(irq), 32'd0);

    // RX burst with overrun
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_sb.push_back(8'(8'hA0 + i));
      rx_byte(8'(8'hA0 + i), 1'b0);
    end
    rd(UART_REG_STATUS, r);
    check("rx_ovr_status", r, 32'h1A);
    check("irq_rx", 32'(irq), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(UART_REG_RXDATA, r);
      check("rx_data", r, 32'(rx_sb.pop_front()));
    end
    rd(UART_REG_STATUS, r);
    check("rx_empty_status", r, 32'h16);
    rd(UART_REG_RXDATA, r);
    check("rx_read_empty", r, 32'h0);
    check("irq_rx_off", 32'(irq), 32'd0);
    wr(UART_REG_CTRL, 32'h1);
    rd(UART_REG_STATUS, r);
    check("rx_sticky_cleared", r, 32'h06);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) begin
      rx_sb.push_back(8'(8'hB0 + i));
      rx_byte(8'(8'hB0 + i), 1'b0);
    end
    uart_rx_data = 8'hB4; uart_rx_flag = 1'b1;
    rd(UART_REG_RXDATA, r);
    check("rx_simul_pop", r, 32'(rx_sb.pop_front()));
    rx_sb.push_back(8'hB4);
    wait_rx_clr("rx_simul_clr");
    uart_rx_flag = 1'b0;
    @(negedge clk);
    rd(UART_REG_STATUS, r);
    check("rx_simul_status", r, 32'h0A);

    // Parity error: byte still stored
    rd(UART_REG_RXDATA, r);
    check("rx_pre_parity_pop", r, 32'(rx_sb.pop_front()));
    rx_sb.push_back(8'h55);
    rx_byte(8'h55, 1'b1);
    rd(UART_REG_STATUS, r);
    check("rx_parity_status", r, 32'h4A);
    for (int i = 0; i < 4; i++) begin
      rd(UART_REG_RXDATA, r);
      check("rx_data2", r, 32'(rx_sb.pop_front()));
    end
    wr(UART_REG_CTRL, 32'h1);
    rd(UART_REG_STATUS, r);
    check("rx_final_status", r, 32'h06);

    // Flush TX while a byte is in flight
    tx_sb.push_back(8'h61);
    wr(UART_REG_TXDATA, 32'h61);
    wr(UART_REG_TXDATA, 32'h62);
    repeat (3) @(negedge clk);
    rd(UART_REG_STATUS, r);
    check("tx_wait_status", r, 32'h84);
    wr(UART_REG_CTRL, 32'h2);
    rd(UART_REG_STATUS, r);
    check("tx_flushed_status", r, 32'h86);
    finish_tx("tx_flush");
    repeat (10) @(negedge clk);
    check("send_count_flush", 32'(sends), 32'd7);
    rd(UART_REG_STATUS, r);
    check("tx_flush_idle", r, 32'h06);

    // Reset asserted while in CLR
    tx_sb.push_back(8'h70);
    wr(UART_REG_TXDATA, 32'h70);
    uart_tx_flag = 1'b1;
    wait_tx_clr("tx_clr_before_rst");
    n_rst = 1'b0;
    #1;
    check("rst_clr_drop", 32'(uart_tx_flag_clr), 32'd0);
    check("rst_tx_data", 32'(uart_tx_data), 32'd0);
    @(negedge clk);
    uart_tx_flag = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    rd(UART_REG_STATUS, r);
    check("rst_status", r, 32'h06);
    check("send_count_final", 32'(sends), 32'd8);
    check("tx_sb_final", 32'(tx_sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
